cnn_stream_loader: RTL and testbench

CNN_STREAM_LOADER -- requirements
Module: cnn_stream_loader

---
 rtl/cnn_loader_pkg.sv | 27 ++
 rtl/cnn_stream_loader.sv | 189 ++++++++++++++++++
 tb/tb_cnn_stream_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_loader_pkg
// Purpose  : Shared constants and types for the CNN stream loader.
//            - Header bytes that select a weight load or an image load.
//            - Default payload sizes: 54 weight bytes (3x3x3 conv plus
//              3x9 fully-connected) and 64 image bytes (8x8 frame).
//            - Loader state encoding.
// Revision : 1.0  initial release
// ============================================================================
package cnn_loader_pkg;

  localparam logic [7:0] HDR_WEIGHT  = 8'hA5;
  localparam logic [7:0] HDR_IMAGE   = 8'h5A;

  localparam int         DEF_W_BYTES = 54;
  localparam int         DEF_D_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_W   = 2'd1,
    ST_LOAD_D   = 2'd2,
    ST_WAIT_RES = 2'd3
  } state_t;

endpackage : cnn_loader_pkg
`default_nettype wire

// File: rtl/cnn_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_loader
// Purpose  : Turns a framed byte stream into write strobes for a CNN core.
//            A header byte in IDLE selects a weight load (0xA5) or an image
//            load (0x5A, only once weights exist). Payload bytes are written
//            to the core one cycle after acceptance. After an image the
//            loader waits for the core's result flag before taking the next
//            header.
// Ports    : clk, rst        clock, asynchronous active-high reset
//            s_valid/s_data  upstream byte stream, s_ready back-pressure
//            mode/ram_en/din core RAM select, write strobe and write byte
//            res_flag        core result-valid flag
//            busy            loader is not idle
//            w_loaded        sticky: a full weight load has completed
//            frame_done      1-cycle pulse when the result flag is seen
//            err             1-cycle pulse on a bad header or a timeout
// Config   : LOADER_TIMEOUT_EN  - when defined, WAIT_RES gives up after
//                                 TIMEOUT cycles and pulses err.
// Revision : 1.0  initial release
// ============================================================================
module cnn_stream_loader
  import cnn_loader_pkg::*;
#(
  parameter int W_BYTES = DEF_W_BYTES,
  parameter int D_BYTES = DEF_D_BYTES,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       mode,
  output logic       ram_en,
  output logic [7:0] din,
  input  logic       res_flag,
  output logic       busy,
  output logic       w_loaded,
  output logic       frame_done,
  output logic       err
);

  localparam int               MAX_BYTES = (W_BYTES > D_BYTES) ? W_BYTES : D_BYTES;
  localparam int               CNT_W     = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(W_BYTES - 1);
  localparam logic [CNT_W-1:0] D_LAST    = CNT_W'(D_BYTES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_loaded_q, w_loaded_d;
  logic             ram_en_q, ram_en_d;
  logic             mode_q, mode_d;
  logic [7:0]       din_q, din_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic             accept;

`ifdef LOADER_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
`endif

  // Ready depends on registered state only, never on s_valid.
  assign s_ready    = (state_q != ST_WAIT_RES);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = s_valid && s_ready;

  assign w_loaded   = w_loaded_q;
  assign ram_en     = ram_en_q;
  assign mode       = mode_q;
  assign din        = din_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_loaded_d   = w_loaded_q;
    ram_en_d     = 1'b0;     // strobe only on the cycle after a payload beat
    mode_d       = mode_q;   // mode/din hold between writes
    din_d        = din_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (s_data == HDR_WEIGHT) begin
            state_d = ST_LOAD_W;
          end else if ((s_data == HDR_IMAGE) && w_loaded_q) begin
            state_d = ST_LOAD_D;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD_W: begin
        if (accept) begin
          ram_en_d = 1'b1;
          mode_d   = 1'b1;
          din_d    = s_data;
          if (cnt_q == W_LAST) begin
            cnt_d      = '0;
            w_loaded_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_LOAD_D: begin
        if (accept) begin
          ram_en_d = 1'b1;
          mode_d   = 1'b0;
          din_d    = s_data;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT_RES;
`ifdef LOADER_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WAIT_RES: begin
        if (res_flag) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
`ifdef LOADER_TIMEOUT_EN
        // Counts WAIT_RES cycles; the TIMEOUT-th cycle without a result
        // gives up so the next err pulse lands TIMEOUT cycles after entry.
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      w_loaded_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      mode_q       <= 1'b0;
      din_q        <= 8'h00;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_loaded_q   <= w_loaded_d;
      ram_en_q     <= ram_en_d;
      mode_q       <= mode_d;
      din_q        <= din_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

endmodule : cnn_stream_loader
`default_nettype wire

// File: tb/tb_cnn_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_stream_loader
// Purpose  : Self-checking bench for cnn_stream_loader. A vector table holds
//            per-cycle inputs and the outputs expected after that clock edge;
//            hand-written sequences cover mid-load reset and WAIT_RES timeout.
// Config   : LOADER_TIMEOUT_EN selects the timeout expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnn_stream_loader;

  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       res_flag = 1'b0;
  logic       s_ready, mode, ram_en, busy, w_loaded, frame_done, err;
  logic [7:0] din;

  cnn_stream_loader #(
    .W_BYTES(54),
    .D_BYTES(64),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mode      (mode),
    .ram_en    (ram_en),
    .din       (din),
    .res_flag  (res_flag),
    .busy      (busy),
    .w_loaded  (w_loaded),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {s_ready, busy, w_loaded, ram_en, mode, din, frame_done, err}
  logic [14:0] obs;
  assign obs = {s_ready, busy, w_loaded, ram_en, mode, din, frame_done, err};

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        rf;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [14:0] ex(input logic rdy, input logic bsy, input logic wl,
                                     input logic en, input logic md, input logic [7:0] dn,
                                     input logic fd, input logic er);
    return {rdy, bsy, wl, en, md, dn, fd, er};
  endfunction

  function automatic void add(input logic v, input logic [7:0] d, input logic r,
                              input logic [14:0] e);
    vec_t t;
    t.sv = v; t.sd = d; t.rf = r; t.exp = e;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/bsy/wl/en/md/din/fd/err=%b_%b_%b_%b_%b_%h_%b_%b expected %b_%b_%b_%b_%b_%h_%b_%b",
               name, act[14], act[13], act[12], act[11], act[10], act[9:2], act[1], act[0],
               exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    s_valid  = v;
    s_data   = d;
    res_flag = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    bit         stuck_ok;

    // ---------------- vector table ----------------
    // Image header before any weights, then two bad headers.
    add(1, 8'h5A, 0, ex(1, 0, 0, 0, 0, 8'h00, 0, 1));
    add(1, 8'h00, 0, ex(1, 0, 0, 0, 0, 8'h00, 0, 1));
    add(1, 8'hFF, 0, ex(1, 0, 0, 0, 0, 8'h00, 0, 1));
    add(0, 8'h00, 0, ex(1, 0, 0, 0, 0, 8'h00, 0, 0));
    // Weight load 0x01..0x36 back-to-back.
    add(1, 8'hA5, 0, ex(1, 1, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 1; i <= 54; i++) begin
      b = 8'(i);
      add(1, b, 0, ex(1, i < 54, i == 54, 1, 1, b, 0, 0));
    end
    add(0, 8'h00, 0, ex(1, 0, 1, 0, 1, 8'h36, 0, 0));
    // res_flag outside WAIT_RES is ignored.
    add(0, 8'h00, 1, ex(1, 0, 1, 0, 1, 8'h36, 0, 0));
    // Image load with a gap after every beat.
    add(1, 8'h5A, 0, ex(1, 1, 1, 0, 1, 8'h36, 0, 0));
    for (int j = 1; j <= 64; j++) begin
      b = 8'(128 + j);
      add(1, b, 0, ex(j < 64, 1, 1, 1, 0, b, 0, 0));
      if (j < 64) add(0, 8'h00, 0, ex(1, 1, 1, 0, 0, b, 0, 0));
    end
    // WAIT_RES: offered bytes are not taken; result on the third cycle.
    add(1, 8'h77, 0, ex(0, 1, 1, 0, 0, 8'hC0, 0, 0));
    add(1, 8'h77, 0, ex(0, 1, 1, 0, 0, 8'hC0, 0, 0));
    add(0, 8'h00, 1, ex(1, 0, 1, 0, 0, 8'hC0, 1, 0));
    add(0, 8'h00, 0, ex(1, 0, 1, 0, 0, 8'hC0, 0, 0));
    // Reload weights while already loaded.
    add(1, 8'hA5, 0, ex(1, 1, 1, 0, 0, 8'hC0, 0, 0));
    for (int i = 1; i <= 54; i++) begin
      b = 8'(255 - i);
      add(1, b, 0, ex(1, i < 54, 1, 1, 1, b, 0, 0));
    end
    add(0, 8'h00, 0, ex(1, 0, 1, 0, 1, 8'hC9, 0, 0));

    // ---------------- reset state ----------------
    #12;
    chk("reset_state", obs, ex(1, 0, 0, 0, 0, 8'h00, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].sv, tbl[k].sd, tbl[k].rf);
      chk($sformatf("vec%0d", k), obs, tbl[k].exp);
    end

    // ---------------- reset during beat 30 of a weight load ----------------
    cyc(1, 8'hA5, 0);
    for (int i = 1; i <= 29; i++) cyc(1, 8'(i), 0);
    chk("pre_reset_beat29", obs, ex(1, 1, 1, 1, 1, 8'h1D, 0, 0));
    s_valid = 1'b1;
    s_data  = 8'h1E;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", obs, ex(1, 0, 0, 0, 0, 8'h00, 0, 0));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    cyc(1, 8'h5A, 0);
    chk("image_after_reset", obs, ex(1, 0, 0, 0, 0, 8'h00, 0, 1));

    // ---------------- fresh weights, then a frame with no result ----------------
    cyc(1, 8'hA5, 0);
    for (int i = 1; i <= 54; i++) cyc(1, 8'(i), 0);
    chk("reload_done", obs, ex(1, 0, 1, 1, 1, 8'h36, 0, 0));
    cyc(1, 8'h5A, 0);
    for (int j = 1; j <= 64; j++) cyc(1, 8'(j), 0);
    chk("enter_wait", obs, ex(0, 1, 1, 1, 0, 8'h40, 0, 0));

`ifdef LOADER_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      cyc(0, 8'h00, 0);
      if (k < TMO)
        chk($sformatf("tmo_wait%0d", k), obs, ex(0, 1, 1, 0, 0, 8'h40, 0, 0));
      else
        chk("tmo_fire", obs, ex(1, 0, 1, 0, 0, 8'h40, 0, 1));
    end
    cyc(0, 8'h00, 0);
    chk("tmo_after", obs, ex(1, 0, 1, 0, 0, 8'h40, 0, 0));
`else
    stuck_ok = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      cyc(0, 8'h00, 0);
      if (obs !== ex(0, 1, 1, 0, 0, 8'h40, 0, 0)) stuck_ok = 1'b0;
    end
    checks++;
    if (!stuck_ok) begin
      errors++;
      $display("FAIL no_timeout_wait: loader left WAIT_RES or pulsed err, expected to stay busy for 300 cycles");
    end
    cyc(0, 8'h00, 1);
    chk("late_result", obs, ex(1, 0, 1, 0, 0, 8'h40, 1, 0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cnn_stream_loader
`default_nettype wire
